// File: rtl/reset_fanout_sequencer_if.sv
// Request/status bundle between the subsystem reset source and the
// reset fanout sequencer. Optional macro RESET_FANOUT_SEQUENCER_ACK_EN
// adds the per-domain ch_ready acknowledge.
interface reset_fanout_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              req_reset;
    logic [NUM_CH-1:0] sw_reset;
    logic [NUM_CH-1:0] ch_reset;
    logic              all_released;

`ifdef RESET_FANOUT_SEQUENCER_ACK_EN
    logic [NUM_CH-1:0] ch_ready;

    modport master (
        output req_reset,
        output sw_reset,
        output ch_ready,
        input  ch_reset,
        input  all_released
    );

    modport slave (
        input  req_reset,
        input  sw_reset,
        input  ch_ready,
        output ch_reset,
        output all_released
    );
`else
    modport master (
        output req_reset,
        output sw_reset,
        input  ch_reset,
        input  all_released
    );

    modport slave (
        input  req_reset,
        input  sw_reset,
        output ch_reset,
        output all_released
    );
`endif
endinterface

// File: rtl/reset_fanout_sequencer.sv
// Reset fanout sequencer: distributes one upstream reset request to NUM_CH
// domains with a minimum-assertion stretch, staggered per-channel release
// and per-channel software reset pulses. All outputs are registered.
// Optional macro RESET_FANOUT_SEQUENCER_ACK_EN: release of the next channel
// (and entry into RUN) additionally waits for the ch_ready acknowledge of
// the most recently released channel, and all_released requires &ch_ready.
module reset_fanout_sequencer #(
    parameter int NUM_CH  = 3,
    parameter int STRETCH = 4,
    parameter int STAGGER = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    reset_fanout_sequencer_if.slave  bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] STRETCH_C    = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] STAGGER_C    = CNT_W'(STAGGER);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  idx_inc;
    logic [NUM_CH-1:0] ch_reset_q;
    logic [NUM_CH-1:0] ch_next;
    logic              all_released_q;
    logic              all_released_next;
    logic              release_done;
    logic              step_ok;
    logic              ready_all;
    logic [CNT_W-1:0]  sw_cnt      [NUM_CH];
    logic [CNT_W-1:0]  sw_cnt_next [NUM_CH];

    // Acknowledge qualifiers; tie off to "always ready" when the handshake is absent
`ifdef RESET_FANOUT_SEQUENCER_ACK_EN
    assign step_ok   = bus.ch_ready[idx];
    assign ready_all = &bus.ch_ready;
`else
    assign step_ok   = 1'b1;
    assign ready_all = 1'b1;
`endif

    // Next-state, counter and output computation; req_reset overrides the state path last
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        ch_next      = ch_reset_q;
        sw_cnt_next  = sw_cnt;
        release_done = 1'b0;
        idx_inc      = idx + 1'b1;

        case (state)
            ST_ASSERT: begin
                ch_next  = '1;
                cnt_next = '0;
                idx_next = '0;
                if (!bus.req_reset) begin
                    state_next = ST_STRETCH;
                end
            end

            ST_STRETCH: begin
                ch_next = '1;
                if (cnt >= STRETCH_LAST) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (cnt == '0) begin
                    ch_next[0] = 1'b0;
                    cnt_next   = CNT_W'(1);
`ifndef RESET_FANOUT_SEQUENCER_ACK_EN
                    if (NUM_CH == 1) begin
                        release_done = 1'b1;
                    end
`endif
                end else if ((idx != LAST_IDX) && (cnt >= STAGGER_C) && step_ok) begin
                    ch_next  = ch_reset_q & ~(NUM_CH'(1) << idx_inc);
                    idx_next = idx_inc;
                    cnt_next = CNT_W'(1);
`ifndef RESET_FANOUT_SEQUENCER_ACK_EN
                    if (idx_inc == LAST_IDX) begin
                        release_done = 1'b1;
                    end
`endif
                end else begin
`ifdef RESET_FANOUT_SEQUENCER_ACK_EN
                    if ((idx == LAST_IDX) && bus.ch_ready[NUM_CH-1]) begin
                        release_done = 1'b1;
                    end
`endif
                    if (cnt < STAGGER_C) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                if (release_done) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end

            ST_RUN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_next[i] = (sw_cnt[i] != '0);
                    if (bus.sw_reset[i]) begin
                        sw_cnt_next[i] = STRETCH_C;
                    end else if (sw_cnt[i] != '0) begin
                        sw_cnt_next[i] = sw_cnt[i] - 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_ASSERT;
                ch_next    = '1;
            end
        endcase

        if (bus.req_reset) begin
            state_next  = ST_ASSERT;
            cnt_next    = '0;
            idx_next    = '0;
            sw_cnt_next = '{default: '0};
        end

        all_released_next = (ch_next == '0) && ((state == ST_RUN) || release_done) && ready_all;
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_ASSERT;
            cnt            <= '0;
            idx            <= '0;
            ch_reset_q     <= '1;
            all_released_q <= 1'b0;
            sw_cnt         <= '{default: '0};
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            idx            <= idx_next;
            ch_reset_q     <= ch_next;
            all_released_q <= all_released_next;
            sw_cnt         <= sw_cnt_next;
        end
    end

    assign bus.ch_reset     = ch_reset_q;
    assign bus.all_released = all_released_q;

endmodule
